// File: rtl/lut_func_unit.sv
`timescale 1ns/1ps
// Programmable N_IN-in / N_OUT-out truth-table function unit with a serial table-load port.
// Latency: 1 cycle from input accept to registered result; full throughput.
// Backpressure: in_ready drops while the result is stalled or a table load/commit is in progress.
module lut_func_unit #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] DEFAULT_TT = 'h31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    input  logic             cfg_start,
    input  logic             cfg_bit_vld,
    input  logic             cfg_bit,
    output logic             cfg_busy,
    output logic             cfg_done
);
    localparam int D  = 2**N_IN;
    localparam int W  = D * N_OUT;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    // Row i of the table is the N_OUT-bit result for input vector i (flat bit i*N_OUT+j).
    logic [D-1:0][N_OUT-1:0] table_q, table_d;
    logic [W-1:0]            shadow_q, shadow_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    out_valid_q, out_valid_d;
    logic [N_OUT-1:0]        out_data_q, out_data_d;
    logic                    accept;

    // Inputs are only taken in RUN and only when the output slot is free or draining now.
    assign in_ready  = !reset && (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_busy  = (state_q != ST_RUN);
    assign cfg_done  = (state_q == ST_COMMIT);

    // Output slot: load on accept (uses the currently active table), clear once drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = table_q[in_data];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Table-load sequencer: shift bits LSB-first into the shadow, swap it in for one COMMIT cycle.
    always_comb begin
        state_d  = state_q;
        table_d  = table_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        case (state_q)
            ST_RUN: begin
                if (cfg_start) begin
                    state_d  = ST_LOAD;
                    shadow_d = '0;
                    count_d  = '0;
                end
            end
            ST_LOAD: begin
                // A restart takes priority over any bit presented in the same cycle.
                if (cfg_start) begin
                    shadow_d = '0;
                    count_d  = '0;
                end else if (cfg_bit_vld) begin
                    shadow_d = {cfg_bit, shadow_q[W-1:1]};
                    count_d  = count_q + 1'b1;
                    if (count_q == CW'(W - 1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                table_d = shadow_q;
                count_d = '0;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers; reset restores the legacy function and drops any partial load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            table_q     <= DEFAULT_TT;
            shadow_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_lut_func_unit.sv
`timescale 1ns/1ps
// Bench for lut_func_unit: default 3-in/1-out instance plus a 2-in/2-out instance.
// Expected results come from a truth-table model, pushed on accept and popped by an output monitor.
// Randomised vectors, table contents, load gaps and sink backpressure.
module tb_lut_func_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic       a_cfg_start, a_cfg_bit_vld, a_cfg_bit, a_cfg_busy, a_cfg_done;
    logic [2:0] a_in_data;
    logic [0:0] a_out_data;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_cfg_start, b_cfg_bit_vld, b_cfg_bit, b_cfg_busy, b_cfg_done;
    logic [1:0] b_in_data, b_out_data;

    int checks = 0;
    int fails  = 0;
    logic [7:0] a_tt = 8'h31;
    logic [7:0] b_tt = 8'h31;
    int qa[$];
    int qb[$];

    lut_func_unit u_a (
        .clk(clk), .reset(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .cfg_start(a_cfg_start), .cfg_bit_vld(a_cfg_bit_vld), .cfg_bit(a_cfg_bit),
        .cfg_busy(a_cfg_busy), .cfg_done(a_cfg_done)
    );

    lut_func_unit #(.N_IN(2), .N_OUT(2)) u_b (
        .clk(clk), .reset(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cfg_start(b_cfg_start), .cfg_bit_vld(b_cfg_bit_vld), .cfg_bit(b_cfg_bit),
        .cfg_busy(b_cfg_busy), .cfg_done(b_cfg_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard producers: on every handshake, queue the model's answer for that vector.
    always @(negedge clk) begin
        if (!rst && a_in_valid && a_in_ready) qa.push_back(int'((a_tt >> a_in_data) & 8'h1));
        if (!rst && b_in_valid && b_in_ready) qb.push_back(int'((b_tt >> (2 * b_in_data)) & 8'h3));
    end

    // Scoreboard consumers: every result taken by the sink must match the oldest queued answer.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; fails++;
                $display("FAIL a_unexpected_out: got %0d, expected no result", a_out_data);
            end else begin
                check("a_out_data", 32'(a_out_data), 32'(qa.pop_front()));
            end
        end
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; fails++;
                $display("FAIL b_unexpected_out: got %0d, expected no result", b_out_data);
            end else begin
                check("b_out_data", 32'(b_out_data), 32'(qb.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic a_send(input logic [2:0] v);
        bit done = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = v;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            done = a_in_ready;
            step();
        end
        a_in_valid = 1'b0;
        if (!done) begin
            checks++; fails++;
            $display("FAIL a_send_timeout: in_ready stayed 0, expected 1 within 40 cycles (v=%0d)", v);
        end
    endtask

    task automatic a_drain(input string name);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (3) step();
        check(name, 32'(qa.size()), 0);
    endtask

    // Enter LOAD; a bit offered alongside cfg_start must not be counted.
    task automatic a_start();
        a_cfg_start   = 1'b1;
        a_cfg_bit_vld = 1'b1;
        a_cfg_bit     = 1'b1;
        step();
        a_cfg_start   = 1'b0;
        a_cfg_bit_vld = 1'b0;
    endtask

    task automatic a_bits(input logic [7:0] tt, input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                a_cfg_bit_vld = 1'b0;
                @(negedge clk);
                check("a_busy_gap", 32'(a_cfg_busy), 1);
                step();
            end
            a_cfg_bit_vld = 1'b1;
            a_cfg_bit     = tt[3'(k)];
            @(negedge clk);
            check("a_busy_load", 32'(a_cfg_busy), 1);
            check("a_in_ready_load", 32'(a_in_ready), 0);
            check("a_done_load", 32'(a_cfg_done), 0);
            step();
        end
        a_cfg_bit_vld = 1'b0;
    endtask

    task automatic a_commit(input logic [7:0] tt);
        @(negedge clk);
        check("a_done_pulse", 32'(a_cfg_done), 1);
        check("a_busy_commit", 32'(a_cfg_busy), 1);
        check("a_in_ready_commit", 32'(a_in_ready), 0);
        step();
        a_tt = tt;
        @(negedge clk);
        check("a_done_after", 32'(a_cfg_done), 0);
        check("a_busy_after", 32'(a_cfg_busy), 0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] v [5];
        logic [7:0] rnd_tt;
        logic [7:0] b_load;
        logic       held;

        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 1; a_cfg_start = 0; a_cfg_bit_vld = 0; a_cfg_bit = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 1; b_cfg_start = 0; b_cfg_bit_vld = 0; b_cfg_bit = 0;
        #2;
        check("rst_in_ready_forced", 32'(a_in_ready), 0);
        check("rst_out_valid", 32'(a_out_valid), 0);
        #10 rst = 1'b0;
        @(negedge clk);
        check("rst_out_data", 32'(a_out_data), 0);
        check("rst_busy", 32'(a_cfg_busy), 0);
        check("rst_done", 32'(a_cfg_done), 0);
        check("rst_in_ready", 32'(a_in_ready), 1);
        step();

        // 1: default table, full-rate stream 0..7.
        a_in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) a_in_data = 3'(i);
            else       a_in_valid = 1'b0;
            @(negedge clk);
            if (i < 8) check("t1_in_ready", 32'(a_in_ready), 1);
            check("t1_out_valid", 32'(a_out_valid), 32'(i > 0));
            step();
        end
        @(negedge clk);
        check("t1_out_valid_end", 32'(a_out_valid), 0);
        a_drain("t1_queue_empty");

        // 2: stall the sink for three cycles with input pending.
        foreach (v[k]) v[k] = 3'($urandom_range(0, 7));
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = v[0];
        step();
        held = a_tt[v[0]];
        a_in_data = v[1];
        repeat (3) begin
            @(negedge clk);
            check("t2_in_ready_stall", 32'(a_in_ready), 0);
            check("t2_out_valid_stall", 32'(a_out_valid), 1);
            check("t2_out_data_stable", 32'(a_out_data), 32'(held));
            step();
        end
        a_out_ready = 1'b1;
        for (int k = 1; k < 5; k++) a_send(v[k]);
        a_drain("t2_queue_empty");

        // 3: reload 8'hFE; an input accepted with cfg_start still sees the old table.
        a_in_valid = 1'b1;
        a_in_data  = 3'd0;
        a_start();
        a_in_valid = 1'b0;
        a_bits(8'hFE, 8);
        a_commit(8'hFE);
        a_send(3'd0);
        a_send(3'd7);
        a_drain("t3_queue_empty");

        // 4: restart mid-load, final table 8'hAA.
        a_start();
        a_bits(8'h00, 5);
        a_cfg_start   = 1'b1;
        a_cfg_bit_vld = 1'b1;
        a_cfg_bit     = 1'b1;
        @(negedge clk);
        check("t4_busy_restart", 32'(a_cfg_busy), 1);
        step();
        a_cfg_start   = 1'b0;
        a_cfg_bit_vld = 1'b0;
        a_bits(8'hAA, 8);
        a_commit(8'hAA);
        a_send(3'd1);
        a_send(3'd2);
        a_drain("t4_queue_empty");

        // Random table, then random traffic with random sink backpressure.
        rnd_tt = 8'($urandom_range(0, 255));
        a_start();
        a_bits(rnd_tt, 8);
        a_commit(rnd_tt);
        for (int c = 0; c < 200; c++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = 3'($urandom_range(0, 7));
            a_out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        a_drain("rnd_queue_empty");

        // 5: reset after four bits of a load.
        a_start();
        a_bits(8'h00, 4);
        #2 rst = 1'b1;
        #1;
        check("t5_busy_in_reset", 32'(a_cfg_busy), 0);
        check("t5_in_ready_in_reset", 32'(a_in_ready), 0);
        check("t5_out_valid_in_reset", 32'(a_out_valid), 0);
        a_tt = 8'h31;
        b_tt = 8'h31;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t5_no_done", 32'(a_cfg_done), 0);
            check("t5_busy", 32'(a_cfg_busy), 0);
            step();
        end
        a_send(3'd4);
        a_send(3'd3);
        a_drain("t5_queue_empty");

        // 6: 2-in/2-out instance loaded with 8'b11_10_01_00 gives identity.
        b_load = 8'b11_10_01_00;
        b_cfg_start = 1'b1;
        step();
        b_cfg_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b_cfg_bit_vld = 1'b1;
            b_cfg_bit     = b_load[3'(k)];
            step();
        end
        b_cfg_bit_vld = 1'b0;
        @(negedge clk);
        check("t6_done_pulse", 32'(b_cfg_done), 1);
        step();
        b_tt = b_load;
        b_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_in_data = 2'(i);
            @(negedge clk);
            check("t6_in_ready", 32'(b_in_ready), 1);
            step();
        end
        b_in_valid = 1'b0;
        repeat (3) step();
        check("t6_queue_empty", 32'(qb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
